// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Holds the operand width, the op codes used by decode/execute and the
// sequencer state encodings.
package muldiv_seq_pkg;

  localparam int unsigned MD_WIDTH = 16;

  // Op codes; bit 1 distinguishes divide ops, bit 0 picks the upper/remainder half
  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_RUN  = 2'd1,
    MDS_DONE = 2'd2
  } mds_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Optional feature macro: MULDIV_DIV_EN (restoring-divide path).
// Ports:
//   i_div   - 1: restoring-divide step, 0: shift-add multiply step
//   i_hi    - acc (multiply) / partial remainder (divide)
//   i_lo    - multiplier (multiply) / quotient-dividend (divide)
//   i_opnd  - multiplicand (multiply) / divisor (divide)
//   o_hi    - next acc / remainder
//   o_lo    - next multiplier / quotient
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  // Shift-add: the 17-bit sum keeps its carry, which shifts into the acc MSB
  always_comb begin
    w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_mul_hi = w_sum[WIDTH:1];
    w_mul_lo = {w_sum[0], i_lo[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_part;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  // Restoring step; the remainder is always < divisor so the difference fits WIDTH bits
  always_comb begin
    w_part = {i_hi, i_lo[WIDTH-1]};
    w_ge   = (w_part >= {1'b0, i_opnd});
    w_diff = WIDTH'(w_part - {1'b0, i_opnd});
    if (w_ge) begin
      w_div_hi = w_diff;
      w_div_lo = {i_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_div_hi = w_part[WIDTH-1:0];
      w_div_lo = {i_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    o_hi = i_div ? w_div_hi : w_mul_hi;
    o_lo = i_div ? w_div_lo : w_mul_lo;
  end
`else
  // Divide datapath absent: the mode select has no effect
  logic w_unused_div;
  assign w_unused_div = i_div;

  always_comb begin
    o_hi = w_mul_hi;
    o_lo = w_mul_lo;
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer for the execute stage.
// Runs WIDTH radix-2 iterations, stalls the pipeline while running and
// presents the result for a single done cycle.
// Optional feature macro: MULDIV_DIV_EN (DIVU/REMU support; absent -> err).
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start, op   - issue request (sampled in IDLE) and op code
//   A, B        - forwarded operands
//   flush       - abort in-flight op
//   stall_req   - pipeline hold (combinational from start in IDLE)
//   busy, done  - state decodes
//   result, err - registered result and error pulse
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mds_state_e       r_state, w_state_n;
  logic [CNT_W-1:0] r_count, w_count_n;
  logic [WIDTH-1:0] r_hi, w_hi_n;
  logic [WIDTH-1:0] r_lo, w_lo_n;
  logic [WIDTH-1:0] r_opnd, w_opnd_n;
  logic [1:0]       r_op, w_op_n;
  logic [WIDTH-1:0] r_result, w_result_n;
  logic             r_err, w_err_n;

  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_div  (md_is_div(r_op)),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .i_opnd (r_opnd),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MDS_IDLE;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_count  <= w_count_n;
      r_hi     <= w_hi_n;
      r_lo     <= w_lo_n;
      r_opnd   <= w_opnd_n;
      r_op     <= w_op_n;
      r_result <= w_result_n;
      r_err    <= w_err_n;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_n  = r_state;
    w_count_n  = r_count;
    w_hi_n     = r_hi;
    w_lo_n     = r_lo;
    w_opnd_n   = r_opnd;
    w_op_n     = r_op;
    w_result_n = r_result;
    w_err_n    = 1'b0;

    case (r_state)
      MDS_IDLE: begin
        if (start && !flush) begin
          w_op_n    = op;
          w_count_n = CNT_W'(WIDTH - 1);
          w_hi_n    = '0;
          if (md_is_div(op)) begin
`ifdef MULDIV_DIV_EN
            // Divide: lo holds the dividend that shifts out into the remainder
            w_lo_n   = A;
            w_opnd_n = B;
            if (B == '0) begin
              w_state_n  = MDS_DONE;
              w_err_n    = 1'b1;
              w_result_n = (op == MD_DIVU) ? '1 : A;
            end else begin
              w_state_n = MDS_RUN;
            end
`else
            w_state_n  = MDS_DONE;
            w_err_n    = 1'b1;
            w_result_n = '0;
`endif
          end else begin
            // Multiply: lo holds the multiplier, A is added on its LSB
            w_lo_n    = B;
            w_opnd_n  = A;
            w_state_n = MDS_RUN;
          end
        end
      end

      MDS_RUN: begin
        if (flush) begin
          w_state_n = MDS_IDLE;
        end else begin
          w_hi_n = w_step_hi;
          w_lo_n = w_step_lo;
          if (r_count == '0) begin
            w_state_n = MDS_DONE;
            // op[0] selects the high product half or the remainder
            w_result_n = r_op[0] ? w_step_hi : w_step_lo;
          end else begin
            w_count_n = r_count - CNT_W'(1);
          end
        end
      end

      MDS_DONE: begin
        w_state_n = MDS_IDLE;
      end

      default: begin
        w_state_n = MDS_IDLE;
      end
    endcase
  end

  assign stall_req = ((r_state == MDS_IDLE) && start && !flush) || (r_state == MDS_RUN);
  assign busy      = (r_state != MDS_IDLE);
  assign done      = (r_state == MDS_DONE);
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver queues expected responses,
// a monitor pops and compares on every done cycle.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        err;

  typedef struct {
    logic [15:0] res;
    logic        e;
    int          lat;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_errs     = 0;
  int   mon_start  = 0;
  int   mon_stalls = 0;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (a),
    .B         (b),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_op(input logic [15:0] r, input logic e, input int lat, input int stalls);
    exp_t x;
    x.res = r; x.e = e; x.lat = lat; x.stalls = stalls;
    sb.push_back(x);
  endtask

  // Drives start for cycle 0 and returns just after the start of cycle 1
  task automatic issue(input logic [1:0] o, input logic [15:0] ai, input logic [15:0] bi);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = ai; b = bi;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errs++;
      $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Monitor: tracks accepted start, counts stall cycles, checks every done
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start && !flush && !busy) begin
          mon_start  = cyc;
          mon_stalls = 0;
        end
        if (stall_req) mon_stalls++;
        if (done) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL unexpected_done: result 0x%0h err %0b with no pending op", result, err);
          end else begin
            exp_t x;
            x = sb.pop_front();
            chk("result", 32'(result), 32'(x.res));
            chk("err", 32'(err), 32'(x.e));
            chk("latency", 32'(cyc - mon_start), 32'(x.lat));
            chk("stall_cycles", 32'(mon_stalls), 32'(x.stalls));
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] prior;
    rst_n = 1'b0; start = 1'b0; op = MD_MUL; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic multiply
    expect_op(16'h1230, 1'b0, 17, 17);
    issue(MD_MUL, 16'h0123, 16'h0010);
    wait_done();

    // Full-scale product, high then low half
    expect_op(16'hFFFE, 1'b0, 17, 17);
    issue(MD_MULHU, 16'hFFFF, 16'hFFFF);
    wait_done();
    expect_op(16'h0001, 1'b0, 17, 17);
    issue(MD_MUL, 16'hFFFF, 16'hFFFF);
    wait_done();

    // Divide 1000 / 7 = 142 r 6
    if (DIV_EN) expect_op(16'h008E, 1'b0, 17, 17);
    else        expect_op(16'h0000, 1'b1, 1, 1);
    issue(MD_DIVU, 16'd1000, 16'd7);
    wait_done();
    if (DIV_EN) expect_op(16'h0006, 1'b0, 17, 17);
    else        expect_op(16'h0000, 1'b1, 1, 1);
    issue(MD_REMU, 16'd1000, 16'd7);
    wait_done();

    // Divide by zero
    if (DIV_EN) expect_op(16'hFFFF, 1'b1, 1, 1);
    else        expect_op(16'h0000, 1'b1, 1, 1);
    issue(MD_DIVU, 16'h1234, 16'h0000);
    wait_done();
    if (DIV_EN) expect_op(16'h1234, 1'b1, 1, 1);
    else        expect_op(16'h0000, 1'b1, 1, 1);
    issue(MD_REMU, 16'h1234, 16'h0000);
    wait_done();
    prior = DIV_EN ? 16'h1234 : 16'h0000;

    // Flush in cycle 5: idle in cycle 6, no done, result held
    issue(MD_MUL, 16'h0003, 16'h0004);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_c5", 32'(busy), 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c6", 32'(busy), 32'h0);
    chk("flush_done_c6", 32'(done), 32'h0);
    chk("flush_result", 32'(result), 32'(prior));
    repeat (20) @(negedge clk);

    // Start pulse in cycle 3 while running is ignored
    expect_op(16'h2100, 1'b0, 17, 17);
    issue(MD_MUL, 16'h0100, 16'h0021);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = MD_MULHU; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Asynchronous reset in cycle 8 of a divide
    if (!DIV_EN) expect_op(16'h0000, 1'b1, 1, 1);
    issue(MD_DIVU, 16'd1000, 16'd7);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_stall", 32'(stall_req), 32'h0);
    chk("arst_result", 32'(result), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh op after reset
    expect_op(16'h000F, 1'b0, 17, 17);
    issue(MD_MUL, 16'd3, 16'd5);
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
